// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch slice.
package pc_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    SEL_PLUS4  = 3'd0,
    SEL_JALR   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JAL    = 3'd3,
    SEL_MTVEC  = 3'd4,
    SEL_MEPC   = 3'd5
  } pc_sel_t;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t BOOT  = 2'd0;
  localparam fetch_state_t FETCH = 2'd1;
  localparam fetch_state_t HOLD  = 2'd2;
  localparam fetch_state_t DRAIN = 2'd3;

endpackage

// File: rtl/pc_next_mux.sv
// Redirect target select plus alignment handling.
// PC_FETCH_MISALIGN_TRAP_EN: flag misaligned targets instead of clearing bits [1:0].
module pc_next_mux
  import pc_fetch_pkg::*;
(
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] jalr,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] jal,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] target_c,
  output logic            misalign_c
);

  logic [XLEN-1:0] raw_c;

  // Reserved encodings fall back to the sequential target.
  always_comb begin
    raw_c = pc_plus4;
    case (pc_sel)
      SEL_JALR:   raw_c = jalr;
      SEL_BRANCH: raw_c = branch;
      SEL_JAL:    raw_c = jal;
      SEL_MTVEC:  raw_c = mtvec;
      SEL_MEPC:   raw_c = mepc;
      default:    raw_c = pc_plus4;
    endcase
  end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  assign target_c   = raw_c;
  assign misalign_c = |raw_c[1:0];
`else
  assign target_c   = raw_c & ~XLEN'(3);
  assign misalign_c = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding REQ/ACK instruction fetch with IR valid/ready handshake.
// PC_FETCH_MISALIGN_TRAP_EN (see pc_next_mux) enables the sticky misaligned-target halt.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            redirect,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] jalr,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] jal,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            ir_ready,
  output logic [XLEN-1:0] pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] ir_pc,
  output logic            ir_valid,
  output logic            fetch_misalign
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc_n, addr_n, ir_n, ir_pc_n;
  logic            req_n, valid_n, mis_n, go_fetch;
  logic [XLEN-1:0] target_c;
  logic            misalign_c;

  pc_next_mux u_pc_next_mux (
    .pc_sel     (pc_sel),
    .pc_plus4   (pc_plus4),
    .jalr       (jalr),
    .branch     (branch),
    .jal        (jal),
    .mtvec      (mtvec),
    .mepc       (mepc),
    .target_c   (target_c),
    .misalign_c (misalign_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_n;
  end

  // Next-state and datapath; redirect is applied first so it overrides sequential advance.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    addr_n   = imem_addr;
    req_n    = imem_req;
    ir_n     = ir;
    ir_pc_n  = ir_pc;
    valid_n  = ir_valid;
    mis_n    = fetch_misalign;
    go_fetch = 1'b0;

    if (redirect) begin
      valid_n = 1'b0;
      if (misalign_c) begin
        mis_n = 1'b1;
      end else begin
        mis_n = 1'b0;
        pc_n  = target_c;
      end
    end

    case (state)
      BOOT: go_fetch = 1'b1;
      FETCH: begin
        if (redirect) begin
          if (imem_ack) go_fetch = 1'b1;
          else          state_n  = DRAIN;
        end else if (imem_ack) begin
          ir_n    = imem_rdata;
          ir_pc_n = imem_addr;
          valid_n = 1'b1;
          pc_n    = pc_plus4;
          req_n   = 1'b0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          go_fetch = 1'b1;
        end else if (ir_ready && !fetch_misalign) begin
          valid_n  = 1'b0;
          go_fetch = 1'b1;
        end
      end
      DRAIN: if (imem_ack) go_fetch = 1'b1;
      default: state_n = BOOT;
    endcase

    // A pending misalign flag parks the unit in HOLD with no request.
    if (go_fetch) begin
      if (mis_n) begin
        state_n = HOLD;
        req_n   = 1'b0;
      end else begin
        state_n = FETCH;
        req_n   = 1'b1;
        addr_n  = pc_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_VECTOR;
      imem_addr      <= RESET_VECTOR;
      imem_req       <= 1'b0;
      ir             <= NOP_INSTR;
      ir_pc          <= RESET_VECTOR;
      ir_valid       <= 1'b0;
      fetch_misalign <= 1'b0;
    end else begin
      pc             <= pc_n;
      imem_addr      <= addr_n;
      imem_req       <= req_n;
      ir             <= ir_n;
      ir_pc          <= ir_pc_n;
      ir_valid       <= valid_n;
      fetch_misalign <= mis_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: cycle table, corner sequences, randomized run against a stream model.
module tb_pc_fetch_unit;
  import pc_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_plus4;
  logic        redirect = 1'b0;
  logic [2:0]  pc_sel = 3'd0;
  logic [31:0] jalr = 32'h500, branch = 32'h300, jal = 32'h100, mtvec = 32'h200, mepc = 32'h400;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        ir_ready = 1'b0;
  logic [31:0] pc, imem_addr, ir, ir_pc;
  logic        imem_req, ir_valid, fetch_misalign;

  int vectors = 0;
  int miscompares = 0;

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_plus4(pc_plus4), .redirect(redirect), .pc_sel(pc_sel),
    .jalr(jalr), .branch(branch), .jal(jal), .mtvec(mtvec), .mepc(mepc),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_ready(ir_ready),
    .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // External incrementer and instruction memory contents.
  assign pc_plus4   = pc + 32'd4;
  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_target();
    logic [31:0] t;
    t = $urandom & 32'h0000_FFFC;
    if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  typedef struct {
    logic        redirect;
    logic [2:0]  sel;
    logic        ack;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] irpc;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[20];

  logic [31:0] m_pc, tgt, prev_addr;
  logic        m_halt, prev_req, prev_ack;
  int          accepted;

  initial begin
    //          redir sel   ack ready | req addr      valid irpc      pc
    tbl[0]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000, 32'h000};
    tbl[1]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h000, 1'b0, 32'h000, 32'h000};
    tbl[2]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 32'h000, 32'h004};
    tbl[3]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h004, 1'b0, 32'h000, 32'h004};
    tbl[4]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h004, 1'b1, 32'h004, 32'h008};
    tbl[5]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 32'h008, 1'b0, 32'h004, 32'h008};
    tbl[6]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 32'h008, 1'b0, 32'h004, 32'h008};
    tbl[7]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h008, 1'b0, 32'h004, 32'h008};
    tbl[8]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h008, 1'b1, 32'h008, 32'h00C};
    tbl[9]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h008, 1'b1, 32'h008, 32'h00C};
    tbl[10] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h008, 1'b1, 32'h008, 32'h00C};
    tbl[11] = '{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 32'h00C, 1'b0, 32'h008, 32'h00C};
    tbl[12] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 32'h00C, 1'b0, 32'h008, 32'h100};
    tbl[13] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h00C, 1'b0, 32'h008, 32'h100};
    tbl[14] = '{1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h008, 32'h100};
    tbl[15] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h008, 32'h300};
    tbl[16] = '{1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 32'h300, 1'b1, 32'h300, 32'h304};
    tbl[17] = '{1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 32'h308, 1'b0, 32'h300, 32'h308};
    tbl[18] = '{1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 32'h308, 1'b0, 32'h300, 32'h200};
    tbl[19] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h300, 32'h400};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ir_nop", ir, NOP_INSTR);
    check("reset_misalign", 32'(fetch_misalign), 32'd0);

    for (int i = 0; i < 20; i++) begin
      redirect = tbl[i].redirect;
      pc_sel   = tbl[i].sel;
      imem_ack = tbl[i].ack;
      ir_ready = tbl[i].ready;
      check($sformatf("row%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      check($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
      check($sformatf("row%0d_valid", i), 32'(ir_valid), 32'(tbl[i].valid));
      check($sformatf("row%0d_irpc", i), ir_pc, tbl[i].irpc);
      check($sformatf("row%0d_pc", i), pc, tbl[i].pc);
      if (tbl[i].valid) check($sformatf("row%0d_ir", i), ir, mem_word(tbl[i].irpc));
      tick();
    end

    // PC wrap at the top of the address space (state: FETCH @0x400, no ack yet).
    redirect = 1'b1; pc_sel = 3'd1; jalr = 32'hFFFF_FFFC; imem_ack = 1'b0; ir_ready = 1'b0;
    tick();
    redirect = 1'b0; imem_ack = 1'b1;
    tick();
    check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_ack = 1'b0;
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_irpc", ir_pc, 32'hFFFF_FFFC);
    check("wrap_ir", ir, mem_word(32'hFFFF_FFFC));
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("wrap_next_addr", imem_addr, 32'h0000_0000);
    check("wrap_next_req", 32'(imem_req), 32'd1);

    // Misaligned JALR target arriving with the ACK.
    redirect = 1'b1; pc_sel = 3'd1; jalr = 32'h0000_0102; imem_ack = 1'b1;
    tick();
    redirect = 1'b0; imem_ack = 1'b0; ir_ready = 1'b1;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    check("mis_flag", 32'(fetch_misalign), 32'd1);
    check("mis_pc_kept", pc, 32'h0000_0000);
    check("mis_valid", 32'(ir_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mis_halt_req%0d", k), 32'(imem_req), 32'd0);
      tick();
    end
    redirect = 1'b1; pc_sel = 3'd4; mtvec = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("mis_clear", 32'(fetch_misalign), 32'd0);
    check("mis_mtvec_addr", imem_addr, 32'h0000_0200);
    check("mis_mtvec_req", 32'(imem_req), 32'd1);
`else
    check("mis_flag", 32'(fetch_misalign), 32'd0);
    check("mis_aligned_addr", imem_addr, 32'h0000_0100);
    check("mis_aligned_req", 32'(imem_req), 32'd1);
    check("mis_aligned_pc", pc, 32'h0000_0100);
`endif
    ir_ready = 1'b0;

    // Reset while a request is outstanding.
    rst = 1'b1;
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_irpc", ir_pc, 32'h0);
    check("rst_ir", ir, NOP_INSTR);
    check("rst_valid", 32'(ir_valid), 32'd0);
    rst = 1'b0;

    // Randomized run: delivered instruction stream must follow the PC rules.
    m_pc = 32'h0; m_halt = 1'b0; accepted = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      redirect = ($urandom_range(0, 19) == 0);
      pc_sel   = 3'($urandom_range(1, 5));
      jalr = rnd_target(); branch = rnd_target(); jal = rnd_target();
      mtvec = rnd_target(); mepc = rnd_target();
      imem_ack = imem_req && ($urandom_range(0, 2) == 0);
      ir_ready = ($urandom_range(0, 1) == 1);

      if (prev_req && !prev_ack) begin
        check("rnd_req_held", 32'(imem_req), 32'd1);
        check("rnd_addr_stable", imem_addr, prev_addr);
      end
      check("rnd_req_while_valid", 32'(imem_req & ir_valid), 32'd0);
      check("rnd_misalign_flag", 32'(fetch_misalign), 32'(m_halt));
      if (ir_valid && ir_ready && !redirect) begin
        check("rnd_irpc", ir_pc, m_pc);
        check("rnd_ir", ir, mem_word(m_pc));
        m_pc = m_pc + 32'd4;
        accepted++;
      end
      if (redirect) begin
        case (pc_sel)
          3'd1:    tgt = jalr;
          3'd2:    tgt = branch;
          3'd3:    tgt = jal;
          3'd4:    tgt = mtvec;
          default: tgt = mepc;
        endcase
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) begin
          m_halt = 1'b1;
        end else begin
          m_halt = 1'b0;
          m_pc   = tgt;
        end
`else
        m_pc = {tgt[31:2], 2'b00};
`endif
      end
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      tick();
    end
    check("rnd_progress", 32'(accepted >= 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
